// File: rtl/irq_seq_pkg.sv
// Shared NPC select codes and vector address for the interrupt sequencer
// and the next-PC mux that consumes its outputs.
package irq_seq_pkg;

    localparam logic [2:0]  NPC_PLUS4  = 3'b000;
    localparam logic [2:0]  NPC_IRQ    = 3'b100;
    localparam logic [2:0]  NPC_MRET   = 3'b101;
    localparam logic [31:0] IRQ_VECTOR = 32'h0000_0010;

endpackage

// File: rtl/irq_seq_edge_latch.sv
// Rising-edge detector feeding a set/clear pending flag; set beats clear so an
// edge arriving in the same cycle as the take is not lost.
module irq_seq_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic clr,
    output logic pending
);

    logic din_d_reg;
    logic pending_reg;
    logic rise;

    assign rise    = din & ~din_d_reg;
    assign pending = pending_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_d_reg   <= 1'b0;
            pending_reg <= 1'b0;
        end else begin
            din_d_reg   <= din;
            pending_reg <= rise | (pending_reg & ~clr);
        end
    end

endmodule

// File: rtl/irq_seq.sv
// Interrupt sequencer beside the EX-stage branch unit: takes pending interrupts,
// redirects to the vector, returns on mret and enforces a hold-off window.
module irq_seq
    import irq_seq_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int HOLDOFF = 2,
    parameter int HOLD_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq_req,
    input  logic            irq_en,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            mret_ex,
    input  logic            mem_busy,
    output logic            interrupt_tick,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic [2:0]      npc_op,
    output logic [PC_W-1:0] epc,
    output logic            irq_ack,
    output logic            in_isr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ISR  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e              state_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [PC_W-1:0]     epc_reg;
    logic                irq_pending;
    logic                take;
    logic                ret;

    irq_seq_edge_latch u_edge_latch (
        .clk     (clk),
        .rst     (rst),
        .din     (irq_req),
        .clr     (take),
        .pending (irq_pending)
    );

    // A redirect needs a real instruction in EX so EPC is always meaningful.
    assign take = (state_reg == ST_IDLE) & irq_pending & irq_en & ex_valid & ~mem_busy;
    assign ret  = (state_reg == ST_ISR) & mret_ex & ex_valid & ~mem_busy;

    always_comb begin
        interrupt_tick = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        npc_op         = NPC_PLUS4;
        irq_ack        = 1'b0;
        in_isr         = (state_reg == ST_ISR);
        if (take) begin
            interrupt_tick = 1'b1;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            npc_op         = NPC_IRQ;
            irq_ack        = 1'b1;
        end else if (ret) begin
            interrupt_tick = 1'b1;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            npc_op         = NPC_MRET;
        end
    end

    assign epc = epc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
            epc_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (take) begin
                        epc_reg   <= ex_pc;
                        state_reg <= ST_ISR;
                    end
                end
                ST_ISR: begin
                    if (ret) begin
                        if (HOLDOFF == 0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg    <= ST_HOLD;
                            hold_cnt_reg <= HOLD_W'(HOLDOFF);
                        end
                    end
                end
                ST_HOLD: begin
                    // Counter runs through stalls; leaving at 1 keeps it from wrapping.
                    hold_cnt_reg <= hold_cnt_reg - 1'b1;
                    if (hold_cnt_reg <= HOLD_W'(1)) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_seq.sv
// Directed bench for irq_seq: each driven cycle pushes its expected outputs to a
// scoreboard queue, which a negedge monitor pops and compares against the DUT.
module tb_irq_seq;
    import irq_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_req;
    logic        irq_en;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        mret_ex;
    logic        mem_busy;
    logic        interrupt_tick;
    logic        ifid_flush;
    logic        idex_flush;
    logic [2:0]  npc_op;
    logic [31:0] epc;
    logic        irq_ack;
    logic        in_isr;

    int n_cmp = 0;
    int n_err = 0;

    logic [39:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    irq_seq #(.PC_W(32), .HOLDOFF(2), .HOLD_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_req        (irq_req),
        .irq_en         (irq_en),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .mret_ex        (mret_ex),
        .mem_busy       (mem_busy),
        .interrupt_tick (interrupt_tick),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .npc_op         (npc_op),
        .epc            (epc),
        .irq_ack        (irq_ack),
        .in_isr         (in_isr)
    );

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got tick/ifid/idex/ack/isr=%b npc=%b epc=%h, want tick/ifid/idex/ack/isr=%b npc=%b epc=%h",
                     tag, obs[39:35], obs[34:32], obs[31:0], expv[39:35], expv[34:32], expv[31:0]);
        end else begin
            $display("ok   %s: tick/ifid/idex/ack/isr=%b npc=%b epc=%h", tag, obs[39:35], obs[34:32], obs[31:0]);
        end
    endtask

    // Expected-vector builders: {tick, ifid_flush, idex_flush, irq_ack, in_isr, npc_op, epc}
    function automatic logic [39:0] e_idle(input logic [31:0] e);
        return {5'b00000, NPC_PLUS4, e};
    endfunction
    function automatic logic [39:0] e_take(input logic [31:0] e);
        return {5'b11110, NPC_IRQ, e};
    endfunction
    function automatic logic [39:0] e_isr(input logic [31:0] e);
        return {5'b00001, NPC_PLUS4, e};
    endfunction
    function automatic logic [39:0] e_ret(input logic [31:0] e);
        return {5'b11101, NPC_MRET, e};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            check(tag_q.pop_front(),
                  {interrupt_tick, ifid_flush, idex_flush, irq_ack, in_isr, npc_op, epc},
                  exp_q.pop_front());
        end
    end

    // Drive one cycle of inputs just after the edge and queue what it must produce.
    task automatic step(input string tag, input bit r, input bit req, input bit en, input bit v,
                        input logic [31:0] pc, input bit mret, input bit busy, input logic [39:0] expv);
        rst      = r;
        irq_req  = req;
        irq_en   = en;
        ex_valid = v;
        ex_pc    = pc;
        mret_ex  = mret;
        mem_busy = busy;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; irq_req = 1'b0; irq_en = 1'b0; ex_valid = 1'b0;
        ex_pc = 32'h0; mret_ex = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 1, 0, 0, 0, 32'h0, 0, 0, e_idle(32'h0));
        for (int i = 0; i < 10; i++)
            step("idle", 0, 0, 1, 1, 32'h40, 0, 0, e_idle(32'h0));
        step("mret_in_idle", 0, 0, 1, 1, 32'h40, 1, 0, e_idle(32'h0));

        // Basic take / return: edge seen, take one cycle later
        step("edge", 0, 1, 1, 1, 32'h40, 0, 0, e_idle(32'h0));
        step("take", 0, 1, 1, 1, 32'h40, 0, 0, e_take(32'h0));
        for (int i = 0; i < 4; i++)
            step("isr", 0, 1, 1, 1, 32'h44, 0, 0, e_isr(32'h40));
        step("isr_req_low", 0, 0, 1, 1, 32'h48, 0, 0, e_isr(32'h40));
        step("mret", 0, 0, 1, 1, 32'h4c, 1, 0, e_ret(32'h40));
        step("hold1", 0, 0, 1, 1, 32'h40, 0, 0, e_idle(32'h40));
        step("hold2", 0, 0, 1, 1, 32'h40, 0, 0, e_idle(32'h40));
        step("idle_after", 0, 0, 1, 1, 32'h44, 0, 0, e_idle(32'h40));

        // Deferral: bubbles then stalls hold the pending take
        step("defer_bubble", 0, 1, 1, 0, 32'h200, 0, 0, e_idle(32'h40));
        step("defer_bubble", 0, 1, 1, 0, 32'h200, 0, 0, e_idle(32'h40));
        step("defer_bubble", 0, 1, 1, 0, 32'h200, 0, 0, e_idle(32'h40));
        step("defer_busy", 0, 1, 1, 1, 32'h204, 0, 1, e_idle(32'h40));
        step("defer_busy", 0, 1, 1, 1, 32'h204, 0, 1, e_idle(32'h40));
        step("take_deferred", 0, 1, 1, 1, 32'h80, 0, 0, e_take(32'h40));
        step("isr2", 0, 0, 1, 1, 32'h10, 0, 0, e_isr(32'h80));
        step("isr2_edge", 0, 1, 1, 1, 32'h14, 0, 0, e_isr(32'h80));
        step("isr2_no_nest", 0, 1, 1, 1, 32'h18, 0, 0, e_isr(32'h80));
        step("mret_busy", 0, 1, 1, 1, 32'h1c, 1, 1, e_isr(32'h80));
        step("mret_bubble", 0, 1, 1, 0, 32'h1c, 1, 0, e_isr(32'h80));
        step("mret2", 0, 1, 1, 1, 32'h1c, 1, 0, e_ret(32'h80));
        step("holdoff1", 0, 1, 1, 1, 32'h80, 0, 0, e_idle(32'h80));
        step("holdoff2_busy", 0, 1, 1, 1, 32'h84, 0, 1, e_idle(32'h80));
        // Branch in EX at 0x100 collides with the take
        step("take_branch", 0, 1, 1, 1, 32'h100, 0, 0, e_take(32'h80));
        step("isr3", 0, 1, 1, 1, 32'h10, 0, 0, e_isr(32'h100));
        step("mret3", 0, 0, 1, 1, 32'h14, 1, 0, e_ret(32'h100));
        step("hold3", 0, 0, 1, 1, 32'h104, 0, 0, e_idle(32'h100));
        step("hold3", 0, 0, 1, 1, 32'h104, 0, 0, e_idle(32'h100));

        // irq_en=0 keeps pending; re-enable coincides with a fresh edge
        step("en0_edge", 0, 1, 0, 1, 32'h300, 0, 0, e_idle(32'h100));
        for (int i = 0; i < 5; i++)
            step("en0_wait", 0, 0, 0, 1, 32'h300, 0, 0, e_idle(32'h100));
        step("take_en_edge", 0, 1, 1, 1, 32'h40, 0, 0, e_take(32'h100));
        step("isr4", 0, 1, 1, 1, 32'h10, 0, 0, e_isr(32'h40));
        step("mret4", 0, 0, 1, 1, 32'h14, 1, 0, e_ret(32'h40));
        step("hold4", 0, 0, 1, 1, 32'h44, 0, 0, e_idle(32'h40));
        step("hold4", 0, 0, 1, 1, 32'h44, 0, 0, e_idle(32'h40));
        step("take_kept_pending", 0, 0, 1, 1, 32'h40, 0, 0, e_take(32'h40));

        // Reset mid-ISR with an edge pending
        step("isr5", 0, 0, 1, 1, 32'h10, 0, 0, e_isr(32'h40));
        step("isr5_edge", 0, 1, 1, 1, 32'h14, 0, 0, e_isr(32'h40));
        step("rst_mid_isr", 1, 0, 1, 1, 32'h18, 0, 0, e_isr(32'h40));
        for (int i = 0; i < 3; i++)
            step("post_rst", 0, 0, 1, 1, 32'h40, 0, 0, e_idle(32'h0));

        @(negedge clk);
        #1;
        check("queue_drained", {8'h0, 32'(exp_q.size())}, 40'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
